// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants and parser state encoding for the UART command parser.
package uart_cmd_parser_pkg;
    localparam logic [7:0] SYNC_BYTE    = 8'hA5;
    localparam logic [7:0] CMD_CSR_WR   = 8'h01;
    localparam logic [7:0] CMD_BUF_A_WR = 8'h02;
    localparam logic [7:0] CMD_BUF_B_WR = 8'h03;
    localparam logic [7:0] CMD_CSR_RD   = 8'h04;
    localparam logic [7:0] CMD_START    = 8'h05;
    localparam logic [7:0] ACK_BYTE     = 8'h06;
    localparam logic [7:0] NAK_BYTE     = 8'h15;

    typedef enum logic [3:0] {
        ST_IDLE, ST_CMD, ST_ADDR_L, ST_ADDR_H, ST_LEN,
        ST_PAYLOAD, ST_CHK, ST_EXEC, ST_RESP, ST_RD_DATA
    } state_e;
endpackage

// File: rtl/uart_cmd_parser_if.sv
// Host-side byte streams plus core-side CSR/buffer/start signals of the parser.
// tx handshake: tx_valid is held with tx_data stable until a cycle with tx_valid && tx_ready.
interface uart_cmd_parser_if #(
    parameter int BUF_AW = 16,
    parameter int CSR_AW = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              csr_we;
    logic              csr_re;
    logic [CSR_AW-1:0] csr_addr;
    logic [31:0]       csr_wdata;
    logic [31:0]       csr_rdata;
    logic              buf_we;
    logic              buf_sel;
    logic [BUF_AW-1:0] buf_addr;
    logic [7:0]        buf_wdata;
    logic              core_busy;
    logic              start;
    logic              overrun;

    modport master (
        input  rx_data, rx_valid, tx_ready, csr_rdata, core_busy,
        output tx_data, tx_valid, csr_we, csr_re, csr_addr, csr_wdata,
               buf_we, buf_sel, buf_addr, buf_wdata, start, overrun
    );
    modport slave (
        output rx_data, rx_valid, tx_ready, csr_rdata, core_busy,
        input  tx_data, tx_valid, csr_we, csr_re, csr_addr, csr_wdata,
               buf_we, buf_sel, buf_addr, buf_wdata, start, overrun
    );
endinterface

// File: rtl/uart_cmd_parser_resp_serializer.sv
// Sends one status byte, optionally followed by a 32-bit word LSB first, over the tx handshake.
module uart_cmd_parser_resp_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [7:0]  first_byte,
    input  logic        has_word,
    input  logic [31:0] word,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        busy
);
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic        has_word_q, has_word_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            word_q     <= '0;
            has_word_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            has_word_q <= has_word_d;
        end
    end

    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        idx_d      = idx_q;
        word_d     = word_q;
        has_word_d = has_word_q;
        if (load) begin
            valid_d    = 1'b1;
            data_d     = first_byte;
            idx_d      = '0;
            word_d     = word;
            has_word_d = has_word;
        end else if (valid_q && tx_ready) begin
            // idx_q counts word bytes already presented; 4 means the word is done
            if (!has_word_q || idx_q == 3'd4) begin
                valid_d = 1'b0;
                data_d  = '0;
            end else begin
                data_d = word_q[{idx_q[1:0], 3'b000} +: 8];
                idx_d  = idx_q + 3'd1;
            end
        end
    end

    assign tx_data  = data_q;
    assign tx_valid = valid_q;
    assign busy     = valid_q;
endmodule

// File: rtl/uart_cmd_parser.sv
// Framed-packet parser: SYNC CMD ADDR_LO ADDR_HI LEN payload CHK, issuing CSR/buffer/start
// actions on the tile core and returning ACK/NAK (plus read data) to the UART transmitter.
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int BUF_AW      = 16,
    parameter int CSR_AW      = 8,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic              clk,
    input  logic              rst,
    uart_cmd_parser_if.master bus,
    output state_e            dbg_state
);
    localparam int TW = $clog2(TIMEOUT_CYC);

    state_e          state_q, state_d;
    logic [7:0]      cmd_q, cmd_d, len_q, len_d, cnt_q, cnt_d, chk_q, chk_d;
    logic [15:0]     addr_q, addr_d;
    logic            chk_ok_q, chk_ok_d, overrun_q, overrun_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            buf_we_q, buf_we_d, buf_sel_q, buf_sel_d;
    logic [BUF_AW-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]      buf_wdata_q, buf_wdata_d;
    logic            ser_load, ser_has_word, ser_busy;
    logic [7:0]      ser_first;
    logic            csr_we_c, csr_re_c, start_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;      cmd_q <= '0;     len_q <= '0;
            cnt_q <= '0;             chk_q <= '0;     addr_q <= '0;
            chk_ok_q <= 1'b0;        overrun_q <= 1'b0; wdata_q <= '0;
            timer_q <= '0;           buf_we_q <= 1'b0; buf_sel_q <= 1'b0;
            buf_addr_q <= '0;        buf_wdata_q <= '0;
        end else begin
            state_q <= state_d;      cmd_q <= cmd_d;  len_q <= len_d;
            cnt_q <= cnt_d;          chk_q <= chk_d;  addr_q <= addr_d;
            chk_ok_q <= chk_ok_d;    overrun_q <= overrun_d; wdata_q <= wdata_d;
            timer_q <= timer_d;      buf_we_q <= buf_we_d; buf_sel_q <= buf_sel_d;
            buf_addr_q <= buf_addr_d; buf_wdata_q <= buf_wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;   cmd_d = cmd_q;     len_d = len_q;
        cnt_d = cnt_q;       chk_d = chk_q;     addr_d = addr_q;
        chk_ok_d = chk_ok_q; overrun_d = overrun_q; wdata_d = wdata_q;
        timer_d = '0;        buf_we_d = 1'b0;   buf_sel_d = buf_sel_q;
        buf_addr_d = buf_addr_q; buf_wdata_d = buf_wdata_q;
        ser_load = 1'b0;     ser_first = NAK_BYTE; ser_has_word = 1'b0;
        csr_we_c = 1'b0;     csr_re_c = 1'b0;   start_c = 1'b0;

        // Inter-byte timeout; a byte arriving in the expiry cycle overrides the abort below
        if (state_q inside {ST_CMD, ST_ADDR_L, ST_ADDR_H, ST_LEN, ST_PAYLOAD, ST_CHK}) begin
            if (bus.rx_valid)
                timer_d = '0;
            else if (timer_q == TW'(TIMEOUT_CYC - 1))
                state_d = ST_IDLE;
            else
                timer_d = timer_q + TW'(1);
        end
        if (bus.rx_valid && state_q inside {ST_EXEC, ST_RESP, ST_RD_DATA})
            overrun_d = 1'b1;

        case (state_q)
            ST_IDLE: if (bus.rx_valid && bus.rx_data == SYNC_BYTE) state_d = ST_CMD;
            ST_CMD: if (bus.rx_valid) begin
                cmd_d = bus.rx_data;
                chk_d = bus.rx_data;
                state_d = ST_ADDR_L;
            end
            ST_ADDR_L: if (bus.rx_valid) begin
                addr_d[7:0] = bus.rx_data;
                chk_d = chk_q ^ bus.rx_data;
                state_d = ST_ADDR_H;
            end
            ST_ADDR_H: if (bus.rx_valid) begin
                addr_d[15:8] = bus.rx_data;
                chk_d = chk_q ^ bus.rx_data;
                state_d = ST_LEN;
            end
            ST_LEN: if (bus.rx_valid) begin
                len_d = bus.rx_data;
                cnt_d = '0;
                wdata_d = '0;
                chk_d = chk_q ^ bus.rx_data;
                state_d = (bus.rx_data == 8'd0) ? ST_CHK : ST_PAYLOAD;
            end
            ST_PAYLOAD: if (bus.rx_valid) begin
                chk_d = chk_q ^ bus.rx_data;
                if (cmd_q == CMD_CSR_WR && cnt_q < 8'd4)
                    wdata_d[{cnt_q[1:0], 3'b000} +: 8] = bus.rx_data;
                // Buffer bytes commit immediately, before the checksum is known
                if (cmd_q == CMD_BUF_A_WR || cmd_q == CMD_BUF_B_WR) begin
                    buf_we_d    = 1'b1;
                    buf_sel_d   = (cmd_q == CMD_BUF_B_WR);
                    buf_addr_d  = BUF_AW'(addr_q) + BUF_AW'(cnt_q);
                    buf_wdata_d = bus.rx_data;
                end
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == len_q - 8'd1) state_d = ST_CHK;
            end
            ST_CHK: if (bus.rx_valid) begin
                chk_ok_d = (bus.rx_data == chk_q);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_RESP;
                ser_load = 1'b1;
                case (cmd_q)
                    CMD_CSR_WR: if (chk_ok_q && len_q == 8'd4) begin
                        csr_we_c = 1'b1;
                        ser_first = ACK_BYTE;
                    end
                    CMD_BUF_A_WR, CMD_BUF_B_WR: if (chk_ok_q) ser_first = ACK_BYTE;
                    CMD_CSR_RD: if (chk_ok_q && len_q == 8'd0) begin
                        csr_re_c = 1'b1;
                        ser_load = 1'b0;
                        state_d = ST_RD_DATA;
                    end
                    CMD_START: if (chk_ok_q && len_q == 8'd0 && !bus.core_busy) begin
                        start_c = 1'b1;
                        ser_first = ACK_BYTE;
                    end
                    default: ser_first = NAK_BYTE;
                endcase
            end
            ST_RD_DATA: begin
                ser_load = 1'b1;
                ser_first = ACK_BYTE;
                ser_has_word = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: if (!ser_busy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    uart_cmd_parser_resp_serializer u_ser (
        .clk(clk), .rst(rst), .load(ser_load), .first_byte(ser_first),
        .has_word(ser_has_word), .word(bus.csr_rdata), .tx_ready(bus.tx_ready),
        .tx_data(bus.tx_data), .tx_valid(bus.tx_valid), .busy(ser_busy)
    );

    assign bus.csr_we    = csr_we_c;
    assign bus.csr_re    = csr_re_c;
    assign bus.csr_addr  = addr_q[CSR_AW-1:0];
    assign bus.csr_wdata = wdata_q;
    assign bus.buf_we    = buf_we_q;
    assign bus.buf_sel   = buf_sel_q;
    assign bus.buf_addr  = buf_addr_q;
    assign bus.buf_wdata = buf_wdata_q;
    assign bus.start     = start_c;
    assign bus.overrun   = overrun_q;
    assign dbg_state     = state_q;
endmodule
